// File: rtl/core_pkg.sv
// Shared definitions for the 2-stage core: ALU opcodes, instruction field
// positions and the architectural register index type.
package core_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SHL = 3'd5,
    ALU_SHR = 3'd6,
    ALU_ASR = 3'd7
  } alu_op_e;

  localparam int INSTR_W = 16;
  localparam int OP_HI   = 15;
  localparam int OP_LO   = 13;
  localparam int IMM_BIT = 12;
  localparam int RD_HI   = 11;
  localparam int RD_LO   = 8;
  localparam int RA_HI   = 7;
  localparam int RA_LO   = 4;
  localparam int RB_HI   = 3;
  localparam int RB_LO   = 0;

  localparam int REG_IDX_W = 4;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_2r1w.sv
// Register file with two combinational read ports and one synchronous write
// port; r0 is hardwired to zero and reads bypass a same-cycle write.
module regfile_2r1w
  import core_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  reg_idx_t         ra_idx,
  input  reg_idx_t         rb_idx,
  output logic [WIDTH-1:0] ra_data,
  output logic [WIDTH-1:0] rb_data,
  input  logic             we,
  input  reg_idx_t         wa,
  input  logic [WIDTH-1:0] wd
);

  logic [WIDTH-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  always_comb begin
    ra_data = regs[ra_idx];
    if (ra_idx == '0)            ra_data = '0;
    else if (we && wa == ra_idx) ra_data = wd;
  end

  always_comb begin
    rb_data = regs[rb_idx];
    if (rb_idx == '0)            rb_data = '0;
    else if (we && wa == rb_idx) rb_data = wd;
  end

endmodule

// File: rtl/operand_issue.sv
// Decode/operand stage: decodes instructions, reads operands with writeback
// bypass, stalls on scoreboard hazards and holds a registered ALU bundle.
module operand_issue
  import core_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         out_op,
  output logic [WIDTH-1:0]   out_a,
  output logic [WIDTH-1:0]   out_b,
  output reg_idx_t           out_rd,
  input  logic               wb_en,
  input  reg_idx_t           wb_rd,
  input  logic [WIDTH-1:0]   wb_data
);

  logic [2:0]       dec_op;
  logic             dec_imm;
  reg_idx_t         dec_rd;
  reg_idx_t         dec_ra;
  reg_idx_t         dec_rb;
  logic [WIDTH-1:0] rf_a;
  logic [WIDTH-1:0] rf_b;
  logic [WIDTH-1:0] operand_b;

  assign dec_op  = in_instr[OP_HI:OP_LO];
  assign dec_imm = in_instr[IMM_BIT];
  assign dec_rd  = in_instr[RD_HI:RD_LO];
  assign dec_ra  = in_instr[RA_HI:RA_LO];
  assign dec_rb  = in_instr[RB_HI:RB_LO];

  regfile_2r1w #(
    .WIDTH(WIDTH),
    .NREGS(NREGS)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .ra_idx (dec_ra),
    .rb_idx (dec_rb),
    .ra_data(rf_a),
    .rb_data(rf_b),
    .we     (wb_en),
    .wa     (wb_rd),
    .wd     (wb_data)
  );

  assign operand_b = dec_imm ? {{(WIDTH-4){in_instr[RB_HI]}}, in_instr[RB_HI:RB_LO]} : rf_b;

  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_next;
  logic             busy_ra;
  logic             busy_rb;
  logic             busy_rd;
  logic             hazard;
  logic             accept;

  // A writeback landing this cycle releases its register early, matching the bypass.
  assign busy_ra = pending[dec_ra] && !(wb_en && wb_rd == dec_ra);
  assign busy_rb = pending[dec_rb] && !(wb_en && wb_rd == dec_rb);
  assign busy_rd = pending[dec_rd] && !(wb_en && wb_rd == dec_rd);
  assign hazard  = busy_ra || (!dec_imm && busy_rb) || busy_rd;

  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  always_comb begin
    pending_next = pending;
    if (wb_en) pending_next[wb_rd] = 1'b0;
    if (accept && dec_rd != '0) pending_next[dec_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= '0;
      out_valid <= 1'b0;
      out_op    <= '0;
      out_a     <= '0;
      out_b     <= '0;
      out_rd    <= '0;
    end else begin
      pending <= pending_next;
      if (accept) begin
        out_valid <= 1'b1;
        out_op    <= dec_op;
        out_a     <= rf_a;
        out_b     <= operand_b;
        out_rd    <= dec_rd;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_issue.sv
// Self-checking bench for operand_issue: directed scenarios followed by random
// traffic, all checked against a register-array / in-flight-list model.
module tb_operand_issue;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_op;
  logic [15:0] out_a;
  logic [15:0] out_b;
  logic [3:0]  out_rd;
  logic        wb_en;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;

  always #5 clk = ~clk;

  operand_issue #(.WIDTH(16), .NREGS(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_instr (in_instr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_op   (out_op),
    .out_a    (out_a),
    .out_b    (out_b),
    .out_rd   (out_rd),
    .wb_en    (wb_en),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] m_regs [16];
  int          m_inflight [$];
  logic        m_valid;
  logic [2:0]  m_op;
  logic [15:0] m_a;
  logic [15:0] m_b;
  logic [3:0]  m_rd;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit in_flight(int r);
    foreach (m_inflight[i]) if (m_inflight[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [15:0] model_read(int r, logic we, int wrd, logic [15:0] wd);
    if (r == 0) return 16'h0000;
    if (we && wrd == r) return wd;
    return m_regs[r];
  endfunction

  function automatic bit model_busy(int r, logic we, int wrd);
    return in_flight(r) && !(we && wrd == r);
  endfunction

  function automatic logic [15:0] mk(int op, int imm, int rd, int ra, int rb);
    return 16'((op << 13) | (imm << 12) | (rd << 8) | (ra << 4) | (rb & 15));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
    m_inflight.delete();
    m_valid = 1'b0;
    m_op    = 3'd0;
    m_a     = 16'h0000;
    m_b     = 16'h0000;
    m_rd    = 4'd0;
  endtask

  // Drives one cycle of inputs, checks in_ready before the edge and the
  // registered bundle after it, advancing the model in between.
  task automatic applyStimulus(input logic v, input logic [15:0] instr, input logic ordy,
                               input logic we, input logic [3:0] wrd, input logic [15:0] wd,
                               input logic r);
    int op, imm, rd, ra, rb, wi;
    bit exp_ready;
    logic [15:0] ea, eb;
    in_valid = v; in_instr = instr; out_ready = ordy;
    wb_en = we; wb_rd = wrd; wb_data = wd; rst = r;
    op  = (int'(instr) >> 13) & 7;
    imm = (int'(instr) >> 12) & 1;
    rd  = (int'(instr) >> 8) & 15;
    ra  = (int'(instr) >> 4) & 15;
    rb  = int'(instr) & 15;
    wi  = int'(wrd);
    exp_ready = (!m_valid || ordy) &&
                !(model_busy(ra, we, wi) || (imm == 0 && model_busy(rb, we, wi)) ||
                  model_busy(rd, we, wi));
    ea = model_read(ra, we, wi, wd);
    eb = (imm != 0) ? 16'((rb < 8) ? rb : rb - 16) : model_read(rb, we, wi, wd);
    #1;
    checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (we && wi != 0) m_regs[wi] = wd;
      if (we) begin
        for (int i = m_inflight.size() - 1; i >= 0; i--)
          if (m_inflight[i] == wi) m_inflight.delete(i);
      end
      if (v && exp_ready) begin
        m_valid = 1'b1;
        m_op = 3'(op); m_a = ea; m_b = eb; m_rd = 4'(rd);
        if (rd != 0 && !in_flight(rd)) m_inflight.push_back(rd);
      end else if (m_valid && ordy) begin
        m_valid = 1'b0;
      end
    end
    #1;
    checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
    checkOutput("out_op", 32'(out_op), 32'(m_op));
    checkOutput("out_a", 32'(out_a), 32'(m_a));
    checkOutput("out_b", 32'(out_b), 32'(m_b));
    checkOutput("out_rd", 32'(out_rd), 32'(m_rd));
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = 16'h0000; out_ready = 1'b1;
    wb_en = 1'b0; wb_rd = 4'd0; wb_data = 16'h0000;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);

    $display("[TB] reset and first issue");
    applyStimulus(0, 16'h0000, 1, 0, 0, 16'h0, 1);
    applyStimulus(1, 16'h0123, 1, 0, 0, 16'h0, 0);
    checkOutput("first_rd", 32'(out_rd), 32'd1);
    checkOutput("first_a", 32'(out_a), 32'd0);
    applyStimulus(1, mk(0, 0, 6, 1, 0), 1, 0, 0, 16'h0, 0);
    applyStimulus(0, 16'h0000, 1, 1, 1, 16'h0011, 0);

    $display("[TB] immediate sign extension");
    applyStimulus(0, 16'h0000, 1, 1, 2, 16'h0005, 0);
    applyStimulus(1, 16'h332F, 1, 0, 0, 16'h0, 0);
    checkOutput("imm_a", 32'(out_a), 32'h0005);
    checkOutput("imm_b", 32'(out_b), 32'hFFFF);
    checkOutput("imm_op", 32'(out_op), 32'd1);

    $display("[TB] RAW stall and bypass");
    applyStimulus(1, mk(0, 0, 4, 0, 0), 1, 0, 0, 16'h0, 0);
    applyStimulus(1, mk(3, 0, 7, 4, 0), 1, 0, 0, 16'h0, 0);
    applyStimulus(1, mk(3, 0, 7, 4, 0), 1, 1, 4, 16'h1234, 0);
    checkOutput("bypass_a", 32'(out_a), 32'h1234);
    checkOutput("bypass_valid", 32'(out_valid), 32'd1);

    $display("[TB] backpressure");
    applyStimulus(0, 16'h0000, 1, 1, 3, 16'h0333, 0);
    applyStimulus(0, 16'h0000, 1, 1, 7, 16'h0777, 0);
    applyStimulus(1, mk(2, 0, 8, 2, 1), 0, 0, 0, 16'h0, 0);
    applyStimulus(1, mk(5, 1, 9, 2, 3), 0, 0, 0, 16'h0, 0);
    checkOutput("held_rd", 32'(out_rd), 32'd8);
    applyStimulus(1, mk(5, 1, 9, 2, 3), 0, 0, 0, 16'h0, 0);
    applyStimulus(1, mk(5, 1, 9, 2, 3), 1, 0, 0, 16'h0, 0);
    checkOutput("second_rd", 32'(out_rd), 32'd9);
    checkOutput("second_b", 32'(out_b), 32'd3);

    $display("[TB] r0 semantics");
    applyStimulus(0, 16'h0000, 1, 1, 0, 16'hBEEF, 0);
    applyStimulus(1, mk(4, 0, 0, 0, 0), 1, 0, 0, 16'h0, 0);
    checkOutput("r0_a", 32'(out_a), 32'd0);
    checkOutput("r0_b", 32'(out_b), 32'd0);
    applyStimulus(1, mk(4, 0, 0, 0, 0), 1, 0, 0, 16'h0, 0);

    $display("[TB] reset mid-operation");
    applyStimulus(1, mk(0, 0, 5, 0, 0), 1, 0, 0, 16'h0, 0);
    applyStimulus(1, mk(0, 0, 10, 5, 0), 0, 0, 0, 16'h0, 1);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    applyStimulus(1, mk(0, 0, 10, 5, 0), 0, 0, 0, 16'h0, 0);
    checkOutput("after_rst_rd", 32'(out_rd), 32'd10);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      logic [3:0] wrd;
      if (m_inflight.size() > 0 && $urandom_range(0, 3) != 0)
        wrd = 4'(m_inflight[$urandom_range(0, m_inflight.size() - 1)]);
      else
        wrd = 4'($urandom_range(0, 15));
      applyStimulus($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 3) != 0,
                    1'($urandom_range(0, 1)), wrd, 16'($urandom), $urandom_range(0, 63) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
